// File: rtl/wb_dma_pkg.sv
// Shared constants for the single-channel Wishbone DMA: register offsets,
// CTRL/STAT bit positions, master FSM encoding and the status word packer.
package wb_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTL_START   = 0;
  localparam int CTL_SRC_INC = 1;
  localparam int CTL_DST_INC = 2;
  localparam int CTL_IRQ_EN  = 3;
  localparam int CTL_ABORT   = 4;
  localparam int CTL_CLEAR   = 5;

  localparam int STA_BUSY    = 0;
  localparam int STA_DONE    = 1;
  localparam int STA_ERR     = 2;
  localparam int STA_IRQ_EN  = 3;
  localparam int STA_SRC_INC = 4;
  localparam int STA_DST_INC = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  localparam int DMA_WORD_BYTES = 4;

  function automatic logic [31:0] pack_stat(input logic busy, input logic done,
                                            input logic err, input logic irq_en,
                                            input logic src_inc, input logic dst_inc);
    logic [31:0] s;
    s              = '0;
    s[STA_BUSY]    = busy;
    s[STA_DONE]    = done;
    s[STA_ERR]     = err;
    s[STA_IRQ_EN]  = irq_en;
    s[STA_SRC_INC] = src_inc;
    s[STA_DST_INC] = dst_inc;
    return s;
  endfunction

endpackage

// File: rtl/wb_dma_regs.sv
// Wishbone slave register file for the DMA: SRC/DST/LEN/CTRL decode,
// done/err status bits and the level interrupt.
module wb_dma_regs
  import wb_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wbs_adr,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  input  logic [3:0]       wbs_sel,
  input  logic             wbs_cyc,
  input  logic             wbs_stb,
  input  logic             wbs_we,
  output logic             wbs_ack,
  input  logic             busy,
  input  logic             done_set,
  input  logic             err_set,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             src_inc,
  output logic             dst_inc,
  output logic             start,
  output logic             abort,
  output logic             irq
);

  logic        acc, wr, ctrl_wr;
  logic [1:0]  sel;
  logic        done, err, irq_en;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{wbs_adr[31:4], wbs_adr[1:0], wbs_sel};

  assign acc     = wbs_cyc & wbs_stb;
  assign wr      = acc & wbs_we;
  assign sel     = wbs_adr[3:2];
  assign ctrl_wr = wr && (sel == REG_CTRL);

  // Start is honoured only from idle; abort only while a transfer runs, so a
  // combined start+abort write from idle simply starts.
  assign start = ctrl_wr & wbs_dat_i[CTL_START] & ~busy;
  assign abort = ctrl_wr & wbs_dat_i[CTL_ABORT] & busy;
  assign irq   = done & irq_en;

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_SRC:  rd_mux = src;
      REG_DST:  rd_mux = dst;
      REG_LEN:  rd_mux = 32'(len);
      REG_CTRL: rd_mux = pack_stat(busy, done, err, irq_en, src_inc, dst_inc);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack   <= 1'b0;
      wbs_dat_o <= '0;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wbs_ack <= acc;
      if (acc) wbs_dat_o <= rd_mux;
      if (wr && !busy) begin
        case (sel)
          REG_SRC:  src <= {wbs_dat_i[31:2], 2'b00};
          REG_DST:  dst <= {wbs_dat_i[31:2], 2'b00};
          REG_LEN:  len <= wbs_dat_i[LEN_W-1:0];
          REG_CTRL: begin
            src_inc <= wbs_dat_i[CTL_SRC_INC];
            dst_inc <= wbs_dat_i[CTL_DST_INC];
          end
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= wbs_dat_i[CTL_IRQ_EN];
      // Later assignments win: a hardware set beats a same-cycle software clear.
      if (ctrl_wr && wbs_dat_i[CTL_CLEAR]) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (start) begin
        done <= (len == '0);
        err  <= 1'b0;
      end
      if (done_set) done <= 1'b1;
      if (err_set)  err  <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_dma_ctrl.sv
// Single-channel Wishbone DMA: register port plus a pipelined master that
// copies one word per read/write pair, releasing the bus for a cycle between words.
module wb_dma_ctrl
  import wb_dma_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic [31:0] wbm_adr,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel,
  output logic        wbm_cyc,
  output logic        wbm_stb,
  output logic        wbm_we,
  input  logic        wbm_ack,
  input  logic        wbm_stall,
  output logic        irq
);

  localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((RD_TIMEOUT > 0) ? RD_TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (RD_TIMEOUT != 0);

  logic [2:0]       state, state_nxt;
  logic [31:0]      cur_src, cur_dst, dbuf;
  logic [LEN_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             abort_pend, tmo_hit, done_set, err_set, busy;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             src_inc, dst_inc, start, abort;

  wb_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wbs_adr  (wbs_adr),
    .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel  (wbs_sel),
    .wbs_cyc  (wbs_cyc),
    .wbs_stb  (wbs_stb),
    .wbs_we   (wbs_we),
    .wbs_ack  (wbs_ack),
    .busy     (busy),
    .done_set (done_set),
    .err_set  (err_set),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .src_inc  (src_inc),
    .dst_inc  (dst_inc),
    .start    (start),
    .abort    (abort),
    .irq      (irq)
  );

  assign busy    = (state != ST_IDLE);
  assign tmo_hit = TMO_EN && (tmo == TMO_LAST);

  // Handshake: a request is accepted on a cycle with stb=1 and stall=0; stb
  // drops the next cycle and exactly one ack is then awaited with cyc held.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE:    if (start && len != '0) state_nxt = ST_RD_REQ;
      ST_RD_REQ:  if (!wbm_stall) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (wbm_ack) state_nxt = ST_WR_REQ;
        else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_WR_REQ:  if (!wbm_stall) state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (wbm_ack) state_nxt = ST_GAP;
        else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end else if (abort_pend || abort) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RD_REQ;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      cnt        <= '0;
      dbuf       <= '0;
      tmo        <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      abort_pend <= (abort_pend | abort) & (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_src <= src;
            cur_dst <= dst;
            cnt     <= len;
          end
        end
        ST_RD_REQ, ST_WR_REQ: tmo <= '0;
        ST_RD_WAIT: begin
          tmo <= tmo + 1'b1;
          if (wbm_ack) dbuf <= wbm_dat_i;
        end
        ST_WR_WAIT: begin
          tmo <= tmo + 1'b1;
          if (wbm_ack) begin
            cnt <= cnt - 1'b1;
            if (src_inc) cur_src <= cur_src + 32'(DMA_WORD_BYTES);
            if (dst_inc) cur_dst <= cur_dst + 32'(DMA_WORD_BYTES);
          end
        end
        default: ;
      endcase
    end
  end

  assign wbs_stall = 1'b0;
  assign wbm_sel   = 4'hF;
  assign wbm_cyc   = (state == ST_RD_REQ) || (state == ST_RD_WAIT) ||
                     (state == ST_WR_REQ) || (state == ST_WR_WAIT);
  assign wbm_stb   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign wbm_we    = (state == ST_WR_REQ);
  assign wbm_dat_o = dbuf;
  assign wbm_adr   = ((state == ST_WR_REQ) || (state == ST_WR_WAIT)) ? cur_dst :
                     ((state == ST_RD_REQ) || (state == ST_RD_WAIT)) ? cur_src : '0;

endmodule
